audio_seq_engine: RTL and testbench

Multi-voice successor to the single-voice music engine. It runs a pattern sequencer with start/stop, loop/one-shot mode and per-channel mute, drives NUM_CH square-wave voices from per-channel pattern ROMs, and mixes them to one 1-bit delta-sigma output for the top-level audio pin. It sits between the system clock/reset and the audio pad; it has no bus interface.

---
 rtl/audio_pkg.sv | 78 +++++++
 rtl/sq_voice.sv | 34 +++
 rtl/audio_seq_engine.sv | 168 ++++++++++++++++
 tb/tb_audio_seq_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the multi-voice audio engine: note half-periods,
// sequencer state encoding and the per-channel pattern ROM.
package audio_pkg;

    // Half-periods in synth ticks; REST silences a voice
    localparam logic [6:0] REST = 7'd0;
    localparam logic [6:0] B1   = 7'd100;
    localparam logic [6:0] D2   = 7'd84;
    localparam logic [6:0] E2   = 7'd74;
    localparam logic [6:0] F2   = 7'd70;
    localparam logic [6:0] G2   = 7'd62;
    localparam logic [6:0] A2   = 7'd55;
    localparam logic [6:0] C3   = 7'd47;
    localparam logic [6:0] D3   = 7'd42;
    localparam logic [6:0] E3   = 7'd37;
    localparam logic [6:0] F3   = 7'd35;
    localparam logic [6:0] A3   = 7'd28;

    // Fixed half-periods used by the short stub pattern
    localparam logic [6:0] STUB_HP0 = 7'd2;
    localparam logic [6:0] STUB_HP1 = 7'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Pattern ROM: half-period for channel ch at pattern position pos.
    // Channel 0 carries an 8-step bassline, channel 1 a 16-step melody that
    // enters after the first 32 positions. Undefined channels stay silent.
    function automatic logic [6:0] pattern_hp(input int unsigned ch,
                                              input logic [6:0] pos,
                                              input logic use_stub);
        logic [6:0] hp;
        hp = REST;
        if (use_stub) begin
            if (ch == 0)
                hp = STUB_HP0;
            else if (ch == 1)
                hp = STUB_HP1;
        end else if (ch == 0) begin
            case (pos[2:0])
                3'd0:    hp = E2;
                3'd1:    hp = E2;
                3'd2:    hp = G2;
                3'd3:    hp = A2;
                3'd4:    hp = E2;
                3'd5:    hp = F2;
                3'd6:    hp = D2;
                default: hp = B1;
            endcase
        end else if (ch == 1) begin
            if (pos[6:5] != 2'd0) begin
                case (pos[3:0])
                    4'd0:    hp = E3;
                    4'd1:    hp = REST;
                    4'd2:    hp = D3;
                    4'd3:    hp = C3;
                    4'd4:    hp = A3;
                    4'd5:    hp = A3;
                    4'd6:    hp = F3;
                    4'd7:    hp = E3;
                    4'd8:    hp = D3;
                    4'd9:    hp = REST;
                    4'd10:   hp = C3;
                    4'd11:   hp = D3;
                    4'd12:   hp = E3;
                    4'd13:   hp = C3;
                    4'd14:   hp = A2;
                    default: hp = REST;
                endcase
            end
        end
        return hp;
    endfunction

endpackage

// File: rtl/sq_voice.sv
// One square-wave voice: a half-period counter that toggles the output bit
// every half_period synth ticks while the voice is active.
module sq_voice
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       active,
    input  logic [6:0] half_period,
    output logic       square
);

    logic [6:0] period_ctr;

    // Advance the period counter on synth ticks; silence clears it to a known phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_ctr <= 7'd0;
            square     <= 1'b0;
        end else if (tick) begin
            if (!active || half_period == REST) begin
                period_ctr <= 7'd0;
                square     <= 1'b0;
            end else if (period_ctr >= half_period - 7'd1) begin
                period_ctr <= 7'd0;
                square     <= ~square;
            end else begin
                period_ctr <= period_ctr + 7'd1;
            end
        end
    end

endmodule

// File: rtl/audio_seq_engine.sv
// Multi-voice pattern sequencer: prescaler, play/stop FSM, NUM_CH square
// voices fed from the pattern ROM, and a first-order delta-sigma mixer that
// folds all voices onto one output pin.
module audio_seq_engine
    import audio_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CTR_W          = 18,
    parameter int SYNTH_BIT      = 10,
    parameter int STEPS_PER_NOTE = 20,
    parameter int GATE_STEPS     = 10,
    parameter int SONG_LEN       = 128,
    parameter bit USE_STUB_ROM   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              loop_mode,
    input  logic [NUM_CH-1:0] mute,
    output logic              audio,
    output logic              busy,
    output logic [6:0]        song_pos,
    output logic              note_strobe
);

    localparam int STEP_W = (STEPS_PER_NOTE > 1) ? $clog2(STEPS_PER_NOTE) : 1;
    localparam int SUM_W  = $clog2(NUM_CH + 1);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_NOTE - 1);
    localparam logic [STEP_W:0]   GATE_LIM  = (STEP_W + 1)'(GATE_STEPS);
    localparam logic [6:0]        POS_LAST  = 7'(SONG_LEN - 1);
    localparam logic [SUM_W:0]    MIX_DIV   = (SUM_W + 1)'(NUM_CH);

    logic [CTR_W-1:0]  presc;
    logic              synth_tick;
    logic              seq_tick;

    seq_state_t        state, state_nxt;
    logic [STEP_W-1:0] step_ctr, step_nxt;
    logic [6:0]        pos_nxt;
    logic              strobe_nxt;
    logic              gate;

    logic [6:0]        hp [NUM_CH];
    logic [NUM_CH-1:0] square;
    logic [SUM_W-1:0]  mix_sum;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W:0]    mix_t;

    // Free-running prescaler; both ticks are decoded from its low bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign synth_tick = &presc[SYNTH_BIT:0];
    assign seq_tick   = &presc;

    // Sequencer state, step counter, position and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            step_ctr    <= '0;
            song_pos    <= 7'd0;
            note_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            step_ctr    <= step_nxt;
            song_pos    <= pos_nxt;
            note_strobe <= strobe_nxt;
        end
    end

    // Next-state logic; dropping en in PLAY wins over a coincident seq_tick,
    // and reaching the song end without loop_mode parks in DONE without a strobe
    always_comb begin
        state_nxt  = state;
        step_nxt   = step_ctr;
        pos_nxt    = song_pos;
        strobe_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                step_nxt = '0;
                pos_nxt  = 7'd0;
                if (en)
                    state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                    pos_nxt   = 7'd0;
                end else if (seq_tick) begin
                    if (step_ctr == STEP_LAST) begin
                        step_nxt = '0;
                        if (song_pos == POS_LAST) begin
                            if (loop_mode) begin
                                pos_nxt    = 7'd0;
                                strobe_nxt = 1'b1;
                            end else begin
                                state_nxt = ST_DONE;
                            end
                        end else begin
                            pos_nxt    = song_pos + 7'd1;
                            strobe_nxt = 1'b1;
                        end
                    end else begin
                        step_nxt = step_ctr + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                    pos_nxt   = 7'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = '0;
                pos_nxt   = 7'd0;
            end
        endcase
    end

    assign busy = (state == ST_PLAY);
    assign gate = (state == ST_PLAY) && ({1'b0, step_ctr} < GATE_LIM);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        assign hp[g] = pattern_hp(g, song_pos, USE_STUB_ROM);

        sq_voice u_voice (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (synth_tick),
            .active      (gate && !mute[g]),
            .half_period (hp[g]),
            .square      (square[g])
        );
    end

    // Count how many voices are currently high
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            mix_sum = mix_sum + SUM_W'(square[i]);
    end

    assign mix_t = {1'b0, acc} + {1'b0, mix_sum};

    // Delta-sigma accumulator: emit a 1 whenever the running sum crosses NUM_CH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            audio <= 1'b0;
        end else if (mix_t >= MIX_DIV) begin
            acc   <= SUM_W'(mix_t - MIX_DIV);
            audio <= 1'b1;
        end else begin
            acc   <= SUM_W'(mix_t);
            audio <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_seq_engine.sv
// Bench for audio_seq_engine: a two-voice and a one-voice instance share the
// sequencer inputs and are compared with a cycle-level behavioural model that
// derives song position from elapsed sequencer ticks, each square from the
// number of active synth ticks, and each audio bit from the running voice sum.
module tb_audio_seq_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       loop_mode;
    logic [1:0] mute2;
    logic [0:0] mute1;
    logic       audio2, busy2, strobe2;
    logic       audio1, busy1, strobe1;
    logic [6:0] pos2, pos1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_cyc;
    int m_mode;
    int m_ticks;
    int m_pos;
    bit m_strobe;
    int m_k  [3];
    bit m_sq [3];
    int m_hp [3] = '{2, 3, 2};
    int m_s2;
    bit m_audio2;
    bit m_audio1;

    audio_seq_engine #(
        .NUM_CH(2), .CTR_W(6), .SYNTH_BIT(1), .STEPS_PER_NOTE(4),
        .GATE_STEPS(2), .SONG_LEN(4), .USE_STUB_ROM(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .loop_mode(loop_mode), .mute(mute2),
        .audio(audio2), .busy(busy2), .song_pos(pos2), .note_strobe(strobe2)
    );

    audio_seq_engine #(
        .NUM_CH(1), .CTR_W(6), .SYNTH_BIT(1), .STEPS_PER_NOTE(4),
        .GATE_STEPS(2), .SONG_LEN(4), .USE_STUB_ROM(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .loop_mode(loop_mode), .mute(mute1),
        .audio(audio1), .busy(busy1), .song_pos(pos1), .note_strobe(strobe1)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cyc = 0; m_mode = 0; m_ticks = 0; m_pos = 0; m_strobe = 0;
        m_s2 = 0; m_audio2 = 0; m_audio1 = 0;
        for (int c = 0; c < 3; c++) begin
            m_k[c] = 0; m_sq[c] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit seq_t, syn_t, gate, muted;
        int sum2, notes;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seq_t = (m_cyc == 63);
        syn_t = (m_cyc % 4) == 3;
        gate  = (m_mode == 1) && ((m_ticks % 4) < 2);
        sum2  = int'(m_sq[0]) + int'(m_sq[1]);
        m_audio2 = ((m_s2 + sum2) / 2) != (m_s2 / 2);
        m_s2     = m_s2 + sum2;
        m_audio1 = m_sq[2];
        if (syn_t) begin
            for (int c = 0; c < 3; c++) begin
                if (c == 2) muted = mute1[0];
                else if (c == 1) muted = mute2[1];
                else muted = mute2[0];
                if (!gate || muted) begin
                    m_k[c] = 0; m_sq[c] = 0;
                end else begin
                    m_k[c] = m_k[c] + 1;
                    m_sq[c] = ((m_k[c] / m_hp[c]) % 2) == 1;
                end
            end
        end
        m_strobe = 0;
        if (m_mode == 0) begin
            if (en) begin m_mode = 1; m_ticks = 0; m_pos = 0; end
        end else if (m_mode == 1) begin
            if (!en) begin
                m_mode = 0; m_ticks = 0; m_pos = 0;
            end else if (seq_t) begin
                m_ticks = m_ticks + 1;
                if (m_ticks % 4 == 0) begin
                    notes = m_ticks / 4;
                    if (notes % 4 == 0) begin
                        if (loop_mode) begin m_pos = 0; m_strobe = 1; end
                        else m_mode = 2;
                    end else begin
                        m_pos = notes % 4; m_strobe = 1;
                    end
                end
            end
        end else begin
            if (!en) begin m_mode = 0; m_ticks = 0; m_pos = 0; end
        end
        m_cyc = (m_cyc + 1) % 64;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; loop_mode = 1'b0; mute2 = 2'b00; mute1 = 1'b0;
        model_reset();
        repeat (3) tick();
        n_checks++;
        if (audio2 !== 1'b0 || audio1 !== 1'b0) $display("[TB] FAIL reset_audio: got %0b/%0b want 0/0", audio2, audio1);
        else n_pass++;
        n_checks++;
        if (busy2 !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy2);
        else n_pass++;
        n_checks++;
        if (pos2 !== 7'd0) $display("[TB] FAIL reset_pos: got %0d want 0", pos2);
        else n_pass++;
        n_checks++;
        if (strobe2 !== 1'b0) $display("[TB] FAIL reset_strobe: got %0b want 0", strobe2);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy2 !== 1'b0) $display("[TB] FAIL idle_busy: got %0b want 0", busy2);
        else n_pass++;
    endtask

    task automatic test_loop_play();
        int nstr, win, hi1, run1, mr1;
        bit started;
        int str_pos [8];
        int str_cyc [8];
        int win_hi  [8];
        int win_mr  [8];
        en = 1'b1; loop_mode = 1'b1; mute2 = 2'b00; mute1 = 1'b0;
        tick();
        n_checks++;
        if (busy2 !== 1'b1) $display("[TB] FAIL busy_after_en: got %0b want 1", busy2);
        else n_pass++;
        nstr = 0; win = 0; started = 0; hi1 = 0; run1 = 0; mr1 = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            n_checks++;
            if (pos2 !== 7'(m_pos) || strobe2 !== m_strobe || audio1 !== m_audio1)
                $display("[TB] FAIL loop_track: got pos=%0d str=%0b a1=%0b want pos=%0d str=%0b a1=%0b",
                         pos2, strobe2, audio1, m_pos, m_strobe, m_audio1);
            else n_pass++;
            if (strobe2 === 1'b1) begin
                if (started && win < 8) begin
                    win_hi[win] = hi1; win_mr[win] = mr1; win++;
                end
                started = 1; hi1 = 0; run1 = 0; mr1 = 0;
                if (nstr < 8) begin str_pos[nstr] = pos2; str_cyc[nstr] = i; end
                nstr++;
            end
            if (started) begin
                if (audio1 === 1'b1) begin
                    hi1++; run1++;
                    if (run1 > mr1) mr1 = run1;
                end else run1 = 0;
            end
        end
        n_checks++;
        if (nstr < 4) $display("[TB] FAIL loop_strobe_count: got %0d want >=4", nstr);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (k < nstr) begin
                n_checks++;
                if (str_pos[k] != (k + 1) % 4) $display("[TB] FAIL loop_pos_seq[%0d]: got %0d want %0d", k, str_pos[k], (k + 1) % 4);
                else n_pass++;
            end
            if (k > 0 && k < nstr) begin
                n_checks++;
                if (str_cyc[k] - str_cyc[k-1] != 256) $display("[TB] FAIL strobe_period[%0d]: got %0d want 256", k, str_cyc[k] - str_cyc[k-1]);
                else n_pass++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k < win) begin
                n_checks++;
                if (win_hi[k] != 64) $display("[TB] FAIL mono_high_count[%0d]: got %0d want 64", k, win_hi[k]);
                else n_pass++;
                n_checks++;
                if (win_mr[k] != 8) $display("[TB] FAIL mono_half_period[%0d]: got %0d want 8", k, win_mr[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_one_shot();
        int nstr;
        en = 1'b0;
        repeat (2) tick();
        loop_mode = 1'b0; en = 1'b1;
        nstr = 0;
        for (int i = 0; i < 1400; i++) begin
            tick();
            if (strobe2 === 1'b1) nstr++;
        end
        n_checks++;
        if (busy2 !== 1'b0 || pos2 !== 7'd3) $display("[TB] FAIL done_state: got busy=%0b pos=%0d want busy=0 pos=3", busy2, pos2);
        else n_pass++;
        n_checks++;
        if (nstr != 3) $display("[TB] FAIL one_shot_strobes: got %0d want 3", nstr);
        else n_pass++;
        n_checks++;
        if (audio2 !== 1'b0) $display("[TB] FAIL done_silent: got %0b want 0", audio2);
        else n_pass++;
        en = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pos2 !== 7'd0 || busy2 !== 1'b0) $display("[TB] FAIL done_to_idle: got busy=%0b pos=%0d want busy=0 pos=0", busy2, pos2);
        else n_pass++;
    endtask

    task automatic test_mute_density();
        int win, hi2, run2, mr2, first_hi;
        bit started;
        mute2 = 2'b10; loop_mode = 1'b1; en = 1'b1;
        win = 0; started = 0; hi2 = 0; run2 = 0; mr2 = 0; first_hi = -1;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (strobe2 === 1'b1) begin
                if (started && win == 0) first_hi = hi2;
                if (started) win++;
                started = 1; hi2 = 0;
            end
            if (audio2 === 1'b1) begin
                hi2++; run2++;
                if (run2 > mr2) mr2 = run2;
            end else run2 = 0;
        end
        n_checks++;
        if (first_hi != 32) $display("[TB] FAIL mute_density: got %0d want 32", first_hi);
        else n_pass++;
        n_checks++;
        if (mr2 != 1) $display("[TB] FAIL mute_max_run: got %0d want 1", mr2);
        else n_pass++;
        en = 1'b0; mute2 = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_en_drop_on_seq_tick();
        int targets [2] = '{3, 1};
        bit found;
        for (int t = 0; t < 2; t++) begin
            en = 1'b1; loop_mode = 1'b1; found = 0;
            for (int i = 0; i < 3000 && !found; i++) begin
                tick();
                if (m_mode == 1 && (m_ticks % 4) == targets[t] && m_cyc == 63 && m_ticks > 4) found = 1;
            end
            n_checks++;
            if (!found) $display("[TB] FAIL en_drop_timeout: got none want step %0d", targets[t]);
            else n_pass++;
            en = 1'b0;
            tick();
            n_checks++;
            if (busy2 !== 1'b0 || pos2 !== 7'd0 || strobe2 !== 1'b0 || pos1 !== 7'd0)
                $display("[TB] FAIL en_drop_idle: got busy=%0b pos=%0d str=%0b want 0/0/0", busy2, pos2, strobe2);
            else n_pass++;
            repeat (6) tick();
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (audio2 !== 1'b0 || audio1 !== 1'b0) $display("[TB] FAIL en_drop_silent: got %0b/%0b want 0/0", audio2, audio1);
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_note();
        bit found;
        en = 1'b1; loop_mode = 1'b1; found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (m_mode == 1 && m_pos == 2 && (m_ticks % 4) == 0 && m_cyc == 20) found = 1;
        end
        n_checks++;
        if (!found || pos2 !== 7'd2) $display("[TB] FAIL reset_setup: got pos=%0d want 2", pos2);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (audio2 !== 1'b0 || audio1 !== 1'b0) $display("[TB] FAIL async_reset_audio: got %0b/%0b want 0/0", audio2, audio1);
        else n_pass++;
        n_checks++;
        if (pos2 !== 7'd0 || busy2 !== 1'b0) $display("[TB] FAIL async_reset_seq: got pos=%0d busy=%0b want 0/0", pos2, busy2);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy2 !== 1'b1 || pos2 !== 7'd0) $display("[TB] FAIL resume_after_reset: got busy=%0b pos=%0d want 1/0", busy2, pos2);
        else n_pass++;
    endtask

    task automatic test_random();
        int len;
        logic [9:0] exp2, exp1;
        for (int ep = 0; ep < 8; ep++) begin
            mute2 = 2'($urandom_range(0, 3));
            mute1 = 1'($urandom_range(0, 1));
            loop_mode = 1'($urandom_range(0, 1));
            en = 1'b1;
            len = $urandom_range(200, 1400);
            for (int i = 0; i < len + 40; i++) begin
                tick();
                exp2 = {m_audio2, (m_mode == 1), 7'(m_pos), m_strobe};
                exp1 = {m_audio1, (m_mode == 1), 7'(m_pos), m_strobe};
                n_checks++;
                if ({audio2, busy2, pos2, strobe2} !== exp2)
                    $display("[TB] FAIL rand_dual ep%0d cyc%0d: got %b want %b", ep, i, {audio2, busy2, pos2, strobe2}, exp2);
                else n_pass++;
                n_checks++;
                if ({audio1, busy1, pos1, strobe1} !== exp1)
                    $display("[TB] FAIL rand_mono ep%0d cyc%0d: got %b want %b", ep, i, {audio1, busy1, pos1, strobe1}, exp1);
                else n_pass++;
                if ($urandom_range(0, 299) == 0) mute2 = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 299) == 0) mute1 = ~mute1;
                if ($urandom_range(0, 199) == 0) loop_mode = ~loop_mode;
                if (i == len) en = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_loop_play();
        test_one_shot();
        test_mute_density();
        test_en_drop_on_seq_tick();
        test_reset_mid_note();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
